// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types and constants.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus: valid/ready request, valid-only in-order response.
interface if_fetch_stage_if;
   import rv32_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
module if_fetch_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic [CW-1:0] count,
   output logic         full,
   output logic         empty
);

   localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a push when the head leaves that cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I fetch stage: PC, credit-limited imem requests, redirect discard.
// Define IF_PERF_CNT_EN to add stall/flush/discard performance counters.
module if_fetch_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   if_fetch_stage_if.master  imem,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pcplus4
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt,
   output logic [31:0]       perf_discard_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = 16;
   localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

   logic [31:0]   pc_q;
   logic [31:0]   rsp_pc_q;
   logic [CW-1:0] outstanding;
   logic [DW-1:0] discard_cnt;
   logic [31:0]   target;
   logic [CW:0]   inflight;
   logic          req_fire;
   logic          rsp_drop;
   logic          live_rsp;
   logic          push;
   logic          pop;
   fetch_entry_t  wdata;
   fetch_entry_t  head;
   logic [CW-1:0] fifo_count;
   logic          full;
   logic          empty;

   assign target   = redirect_pc & 32'hFFFF_FFFC;
   assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};

   assign imem.req_valid = !reset && !redirect_valid
                        && (inflight < DEPTH_C);
   assign imem.req_addr  = pc_q;

   assign req_fire = imem.req_valid && imem.req_ready;
   assign rsp_drop = imem.rsp_valid && (discard_cnt != '0);
   assign live_rsp = imem.rsp_valid && (discard_cnt == '0);
   assign push     = live_rsp && !redirect_valid;
   assign pop      = id_valid && id_ready && !redirect_valid;
   assign wdata    = '{instr: imem.rsp_data, pc: rsp_pc_q};

   // Live requests move into the discard pool on redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         rsp_pc_q    <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
      end else if (redirect_valid) begin
         pc_q        <= target;
         rsp_pc_q    <= target;
         outstanding <= '0;
         discard_cnt <= discard_cnt + DW'(outstanding)
                      - DW'(imem.rsp_valid);
      end else begin
         if (req_fire)
            pc_q <= pc_q + 32'd4;
         if (push)
            rsp_pc_q <= rsp_pc_q + 32'd4;
         outstanding <= outstanding + CW'(req_fire)
                      - CW'(live_rsp);
         discard_cnt <= discard_cnt - DW'(rsp_drop);
      end
   end

   if_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wdata),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign id_valid   = !empty;
   assign id_instr   = empty ? NOP : head.instr;
   assign id_pc      = empty ? 32'd0 : head.pc;
   assign id_pcplus4 = id_pc + 32'd4;

   push_into_full: assert property (
      @(posedge clk) disable iff (reset)
      !(push && full && !pop)
   );

`ifdef IF_PERF_CNT_EN
   logic stall_ev;
   logic disc_ev;

   assign stall_ev = id_valid && !id_ready;
   assign disc_ev  = imem.rsp_valid
                  && (redirect_valid || discard_cnt != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt   <= '0;
         perf_flush_cnt   <= '0;
         perf_discard_cnt <= '0;
      end else begin
         if (stall_ev && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_valid && perf_flush_cnt != '1)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         if (disc_ev && perf_discard_cnt != '1)
            perf_discard_cnt <= perf_discard_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: latency-programmable imem model plus scoreboard.
module tb_if_fetch_stage;
   import rv32_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b1;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pcplus4;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_discard_cnt;
`endif

   if_fetch_stage_if imem_bus();

   if_fetch_stage #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem           (imem_bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pcplus4     (id_pcplus4)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_stall_cnt   (perf_stall_cnt),
      .perf_flush_cnt   (perf_flush_cnt),
      .perf_discard_cnt (perf_discard_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } mreq_t;

   int vectors = 0;
   int miscompares = 0;
   int lat = 1;
   int cyc = 0;
   int epoch = 0;
   int delivered = 0;
   int n_stall = 0;
   int n_flush = 0;
   int n_disc = 0;

   mreq_t        mq [$];
   fetch_entry_t exp_q [$];
   logic [31:0]  exp_fetch_pc = RST_PC;
   mreq_t        mr;
   fetch_entry_t me;

   function automatic logic [31:0] image(input logic [31:0] a);
      return ~a ^ 32'h00C0_FFEE;
   endfunction

   initial begin
      imem_bus.req_ready = 1'b1;
      imem_bus.rsp_valid = 1'b0;
      imem_bus.rsp_data  = '0;
   end

   // Memory model and decode-side scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      #2;
      if (reset) begin
         mq.delete();
         exp_q.delete();
         exp_fetch_pc = RST_PC;
         imem_bus.rsp_valid = 1'b0;
         cyc = 0;
         n_stall = 0;
         n_flush = 0;
         n_disc = 0;
      end else begin
         cyc++;
         imem_bus.rsp_valid = 1'b0;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            mr = mq.pop_front();
            imem_bus.rsp_valid = 1'b1;
            imem_bus.rsp_data  = image(mr.addr);
            if (redirect_valid || mr.ep != epoch)
               n_disc++;
         end
         if (imem_bus.req_valid && imem_bus.req_ready) begin
            vectors++;
            if (imem_bus.req_addr !== exp_fetch_pc) begin
               miscompares++;
               $display("FAIL req_addr: got %h want %h",
                        imem_bus.req_addr, exp_fetch_pc);
            end
            mq.push_back('{addr: imem_bus.req_addr,
                           due: cyc + lat, ep: epoch});
            exp_q.push_back('{instr: image(exp_fetch_pc),
                              pc: exp_fetch_pc});
            exp_fetch_pc += 32'd4;
         end
         if (id_valid && !id_ready)
            n_stall++;
         if (redirect_valid) begin
            n_flush++;
            epoch++;
            exp_q.delete();
            exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            vectors++;
            if (imem_bus.req_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL req_in_redirect: got %b want 0",
                        imem_bus.req_valid);
            end
         end else if (id_valid && id_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL stale_id: got pc %h want none", id_pc);
            end else begin
               me = exp_q.pop_front();
               delivered++;
               if (id_pc !== me.pc || id_instr !== me.instr
                   || id_pcplus4 !== me.pc + 32'd4) begin
                  miscompares++;
                  $display("FAIL id_out: got %h/%h/%h want %h/%h/%h",
                           id_pc, id_instr, id_pcplus4,
                           me.pc, me.instr, me.pc + 32'd4);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic apply_reset(input int l);
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      imem_bus.req_ready = 1'b1;
      lat = l;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_id_valid(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (id_valid) ok = 1'b1;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got id_valid 0 want 1", nm);
      end
   endtask

   task automatic do_redirect(input logic [31:0] tgt, input int n);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = tgt;
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset(1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_req_valid", 32'(imem_bus.req_valid), 32'd0);
      chk("rst_req_addr", imem_bus.req_addr, RST_PC);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_instr", id_instr, 32'h0000_0013);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_id_pcplus4", id_pcplus4, 32'd4);
   endtask

   task automatic test_stream();
      int d0;
      apply_reset(1);
      #1;
      chk("stream_req_valid", 32'(imem_bus.req_valid), 32'd1);
      chk("stream_first_addr", imem_bus.req_addr, RST_PC);
      chk("stream_c1_valid", 32'(id_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("stream_c2_valid", 32'(id_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("stream_c3_valid", 32'(id_valid), 32'd1);
      chk("stream_c3_pc", id_pc, RST_PC);
      d0 = delivered;
      repeat (30) @(negedge clk);
      vectors++;
      if (delivered - d0 < 20) begin
         miscompares++;
         $display("FAIL stream_rate: got %0d want >=20",
                  delivered - d0);
      end
   endtask

   task automatic test_stall();
      int d0;
      apply_reset(1);
      wait_id_valid("stall");
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         chk("stall_valid", 32'(id_valid), 32'd1);
         chk("stall_pc", id_pc, RST_PC);
         if (i >= 1)
            chk("stall_no_req", 32'(imem_bus.req_valid), 32'd0);
      end
      @(negedge clk);
      id_ready = 1'b1;
      d0 = delivered;
      repeat (15) @(negedge clk);
      vectors++;
      if (delivered - d0 < 8) begin
         miscompares++;
         $display("FAIL stall_resume: got %0d want >=8",
                  delivered - d0);
      end
   endtask

   task automatic test_redirect();
      apply_reset(3);
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("redir_id_valid", 32'(id_valid), 32'd0);
      chk("redir_req_valid", 32'(imem_bus.req_valid), 32'd1);
      chk("redir_req_addr", imem_bus.req_addr, 32'h0000_0100);
      wait_id_valid("redir");
      chk("redir_first_pc", id_pc, 32'h0000_0100);
      repeat (10) @(negedge clk);
   endtask

   task automatic test_misaligned();
      do_redirect(32'h0000_0203, 1);
      chk("misal_req_addr", imem_bus.req_addr, 32'h0000_0200);
      wait_id_valid("misal");
      chk("misal_pc", id_pc, 32'h0000_0200);
      chk("misal_instr", id_instr, image(32'h0000_0200));
      repeat (6) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      repeat (2) @(negedge clk);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      @(negedge clk);
      redirect_pc = 32'h0000_0080;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("b2b_req_addr", imem_bus.req_addr, 32'h0000_0080);
      chk("b2b_id_valid", 32'(id_valid), 32'd0);
      wait_id_valid("b2b");
      chk("b2b_first_pc", id_pc, 32'h0000_0080);
      repeat (15) @(negedge clk);
   endtask

   task automatic test_wrap();
      lat = 1;
      do_redirect(32'hFFFF_FFFC, 1);
      chk("wrap_addr0_valid", 32'(imem_bus.req_valid), 32'd1);
      chk("wrap_addr0", imem_bus.req_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      chk("wrap_addr1_valid", 32'(imem_bus.req_valid), 32'd1);
      chk("wrap_addr1", imem_bus.req_addr, 32'h0000_0000);
      wait_id_valid("wrap");
      chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap_pcplus4", id_pcplus4, 32'h0000_0000);
      repeat (6) @(negedge clk);
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic test_perf();
      apply_reset(2);
      repeat (4) @(negedge clk);
      id_ready = 1'b0;
      repeat (3) @(negedge clk);
      id_ready = 1'b1;
      do_redirect(32'h0000_0300, 1);
      repeat (2) @(negedge clk);
      do_redirect(32'h0000_0400, 2);
      repeat (10) @(negedge clk);
      #1;
      chk("perf_stall", perf_stall_cnt, 32'(n_stall));
      chk("perf_flush", perf_flush_cnt, 32'(n_flush));
      chk("perf_discard", perf_discard_cnt, 32'(n_disc));
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misaligned();
      test_back_to_back();
      test_wrap();
`ifdef IF_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
